// File: rtl/branch_pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_pc_unit_if
// Description : Decode/ALU inputs and PC-stage outputs of branch_pc_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_pc_unit_if;
    logic        stall;
    logic        instr_valid;
    logic        is_branch;
    logic        is_jump;
    logic        is_jump_reg;
    logic        alu_zero;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] reg_target;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        in_delay_slot;
    logic        active;

    modport master (
        output stall, instr_valid, is_branch, is_jump, is_jump_reg,
               alu_zero, imm16, target26, reg_target,
        input  pc, link_addr, in_delay_slot, active
    );

    modport slave (
        input  stall, instr_valid, is_branch, is_jump, is_jump_reg,
               alu_zero, imm16, target26, reg_target,
        output pc, link_addr, in_delay_slot, active
    );
endinterface
`default_nettype wire

// File: rtl/branch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_pc_unit
// Description : Architectural PC with MIPS branch delay slot and JR-to-0 halt.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  wire logic       clk,
    input  wire logic       reset,
    branch_pc_unit_if.slave bus
);

    typedef enum logic [1:0] {
        ST_SEQ        = 2'd0,
        ST_DELAY      = 2'd1,
        ST_HALT_DELAY = 2'd2,
        ST_HALTED     = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic        active_q, active_d;

    logic        w_adv;
    logic        w_redir;
    logic        w_halt_req;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_target;

    assign w_adv       = bus.instr_valid & ~bus.stall & active_q;
    assign w_pc_plus4  = pc_q + 32'd4;
    assign w_br_target = w_pc_plus4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    assign w_j_target  = {w_pc_plus4[31:28], bus.target26, 2'b00};
    assign w_redir     = bus.is_jump | bus.is_jump_reg | (bus.is_branch & bus.alu_zero);
    assign w_halt_req  = bus.is_jump_reg & (bus.reg_target == HALT_ADDR);

    // Jump-register outranks jump, which outranks a conditional branch.
    always_comb begin
        w_target = w_br_target;
        if (bus.is_jump_reg) begin
            w_target = bus.reg_target;
        end else if (bus.is_jump) begin
            w_target = w_j_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_SEQ;
            pc_q     <= RESET_VECTOR;
            target_q <= 32'd0;
            active_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            active_q <= active_d;
        end
    end

    // Redirects seen while already in a delay slot are dropped: first target wins.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        active_d = active_q;
        case (state_q)
            ST_SEQ: begin
                if (w_adv) begin
                    pc_d = w_pc_plus4;
                    if (w_redir) begin
                        target_d = w_target;
                        state_d  = w_halt_req ? ST_HALT_DELAY : ST_DELAY;
                    end
                end
            end
            ST_DELAY: begin
                if (w_adv) begin
                    pc_d    = target_q;
                    state_d = ST_SEQ;
                end
            end
            ST_HALT_DELAY: begin
                if (w_adv) begin
                    pc_d     = HALT_ADDR;
                    active_d = 1'b0;
                    state_d  = ST_HALTED;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_SEQ;
            end
        endcase
    end

    assign bus.pc            = pc_q;
    assign bus.link_addr     = pc_q + 32'd8;
    assign bus.in_delay_slot = (state_q == ST_DELAY) | (state_q == ST_HALT_DELAY);
    assign bus.active        = active_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_pc_unit
// Description : Directed and randomized checks of branch_pc_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_pc_unit;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    branch_pc_unit_if bus ();

    branch_pc_unit #(
        .RESET_VECTOR (32'hBFC00000),
        .HALT_ADDR    (32'h00000000)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the address of the next instruction and any redirect
    // owed after the current delay slot.
    logic [31:0] m_pc;
    logic        m_slot;
    logic [31:0] m_target;
    logic        m_halting;
    logic        m_active;

    task automatic model_reset();
        m_pc      = 32'hBFC00000;
        m_slot    = 1'b0;
        m_target  = 32'd0;
        m_halting = 1'b0;
        m_active  = 1'b1;
    endtask

    task automatic model_edge();
        logic [31:0] nxt;
        logic [31:0] offs;
        if (reset) begin
            model_reset();
        end else if (bus.instr_valid && !bus.stall && m_active) begin
            nxt = m_pc + 32'd4;
            if (m_slot) begin
                m_pc   = m_target;
                m_slot = 1'b0;
                if (m_halting) m_active = 1'b0;
            end else begin
                offs = 32'(signed'(bus.imm16)) * 32'd4;
                if (bus.is_jump_reg) begin
                    m_target  = bus.reg_target;
                    m_slot    = 1'b1;
                    m_halting = (bus.reg_target == 32'd0);
                end else if (bus.is_jump) begin
                    m_target  = (nxt & 32'hF0000000) | ({6'd0, bus.target26} * 32'd4);
                    m_slot    = 1'b1;
                    m_halting = 1'b0;
                end else if (bus.is_branch && bus.alu_zero) begin
                    m_target  = nxt + offs;
                    m_slot    = 1'b1;
                    m_halting = 1'b0;
                end
                m_pc = nxt;
            end
        end
    endtask

    task automatic clear_inputs();
        bus.stall       = 1'b0;
        bus.instr_valid = 1'b0;
        bus.is_branch   = 1'b0;
        bus.is_jump     = 1'b0;
        bus.is_jump_reg = 1'b0;
        bus.alu_zero    = 1'b0;
        bus.imm16       = 16'd0;
        bus.target26    = 26'd0;
        bus.reg_target  = 32'd0;
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        #2;
        model_reset();
        reset = 1'b0;
    endtask

    task automatic plain(input int n);
        clear_inputs();
        bus.instr_valid = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.pc, bus.in_delay_slot, bus.active, bus.link_addr} !== {32'hBFC00000, 1'b0, 1'b1, 32'hBFC00008}) begin
            n_fail++;
            $display("FAIL reset: pc=%h ds=%b act=%b link=%h, expected pc=BFC00000 ds=0 act=1 link=BFC00008",
                     bus.pc, bus.in_delay_slot, bus.active, bus.link_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc = '{32'hBFC00004, 32'hBFC00008, 32'hBFC0000C};
        clear_inputs();
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({bus.pc, bus.in_delay_slot, bus.active} !== {exp_pc[i], 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL seq[%0d]: pc=%h ds=%b act=%b, expected pc=%h ds=0 act=1",
                         i, bus.pc, bus.in_delay_slot, bus.active, exp_pc[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] exp_pc [2];
        logic        exp_ds [2];
        for (int taken = 1; taken >= 0; taken--) begin
            do_reset();
            plain(4);
            if (taken == 1) begin
                exp_pc = '{32'hBFC00014, 32'hBFC00004};
                exp_ds = '{1'b1, 1'b0};
            end else begin
                exp_pc = '{32'hBFC00014, 32'hBFC00018};
                exp_ds = '{1'b0, 1'b0};
            end
            bus.is_branch = 1'b1;
            bus.alu_zero  = (taken == 1);
            bus.imm16     = 16'hFFFC;
            for (int i = 0; i < 2; i++) begin
                tick();
                clear_inputs();
                bus.instr_valid = 1'b1;
                n_cmp++;
                if ({bus.pc, bus.in_delay_slot} !== {exp_pc[i], exp_ds[i]}) begin
                    n_fail++;
                    $display("FAIL branch taken=%0d step %0d: pc=%h ds=%b, expected pc=%h ds=%b",
                             taken, i, bus.pc, bus.in_delay_slot, exp_pc[i], exp_ds[i]);
                end
            end
        end
    endtask

    task automatic test_jump();
        logic [31:0] exp_pc [2];
        exp_pc = '{32'hBFC00024, 32'hB0000400};
        do_reset();
        plain(8);
        bus.is_jump  = 1'b1;
        bus.target26 = 26'h0000100;
        for (int i = 0; i < 2; i++) begin
            tick();
            clear_inputs();
            bus.instr_valid = 1'b1;
            n_cmp++;
            if ({bus.pc, bus.in_delay_slot} !== {exp_pc[i], (i == 0)}) begin
                n_fail++;
                $display("FAIL jump step %0d: pc=%h ds=%b, expected pc=%h ds=%b",
                         i, bus.pc, bus.in_delay_slot, exp_pc[i], (i == 0));
            end
        end
    endtask

    task automatic test_stall_in_delay();
        do_reset();
        bus.instr_valid = 1'b1;
        bus.is_branch   = 1'b1;
        bus.alu_zero    = 1'b1;
        bus.imm16       = 16'h0008;
        tick();
        bus.stall = 1'b1;
        bus.imm16 = 16'h0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({bus.pc, bus.in_delay_slot} !== {32'hBFC00004, 1'b1}) begin
                n_fail++;
                $display("FAIL stall cycle %0d: pc=%h ds=%b, expected pc=BFC00004 ds=1",
                         i, bus.pc, bus.in_delay_slot);
            end
        end
        bus.stall = 1'b0;
        tick();
        n_cmp++;
        if ({bus.pc, bus.in_delay_slot} !== {32'hBFC00024, 1'b0}) begin
            n_fail++;
            $display("FAIL stall release: pc=%h ds=%b, expected pc=BFC00024 ds=0",
                     bus.pc, bus.in_delay_slot);
        end
        plain(1);
        n_cmp++;
        if ({bus.pc, bus.in_delay_slot} !== {32'hBFC00028, 1'b0}) begin
            n_fail++;
            $display("FAIL stall second branch: pc=%h ds=%b, expected pc=BFC00028 ds=0",
                     bus.pc, bus.in_delay_slot);
        end
    endtask

    task automatic test_halt();
        do_reset();
        plain(12);
        bus.is_jump_reg = 1'b1;
        bus.reg_target  = 32'd0;
        tick();
        n_cmp++;
        if ({bus.pc, bus.in_delay_slot, bus.active} !== {32'hBFC00034, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL halt delay: pc=%h ds=%b act=%b, expected pc=BFC00034 ds=1 act=1",
                     bus.pc, bus.in_delay_slot, bus.active);
        end
        plain(1);
        n_cmp++;
        if ({bus.pc, bus.in_delay_slot, bus.active} !== {32'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL halt entry: pc=%h ds=%b act=%b, expected pc=0 ds=0 act=0",
                     bus.pc, bus.in_delay_slot, bus.active);
        end
        bus.is_jump = 1'b1;
        bus.target26 = 26'h3FFFFFF;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if ({bus.pc, bus.active, bus.link_addr} !== {32'h0, 1'b0, 32'h8}) begin
            n_fail++;
            $display("FAIL halted hold: pc=%h act=%b link=%h, expected pc=0 act=0 link=8",
                     bus.pc, bus.active, bus.link_addr);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.instr_valid = 1'b1;
        bus.is_branch   = 1'b1;
        bus.alu_zero    = 1'b1;
        bus.imm16       = 16'h0040;
        tick();
        clear_inputs();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if ({bus.pc, bus.in_delay_slot, bus.active} !== {32'hBFC00000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL async reset: pc=%h ds=%b act=%b, expected pc=BFC00000 ds=0 act=1",
                     bus.pc, bus.in_delay_slot, bus.active);
        end
        reset = 1'b0;
        plain(1);
        n_cmp++;
        if ({bus.pc, bus.in_delay_slot} !== {32'hBFC00004, 1'b0}) begin
            n_fail++;
            $display("FAIL after async reset: pc=%h ds=%b, expected pc=BFC00004 ds=0",
                     bus.pc, bus.in_delay_slot);
        end
    endtask

    task automatic test_random();
        int halted_cycles;
        halted_cycles = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bus.instr_valid = ($urandom_range(0, 9) < 8);
            bus.stall       = ($urandom_range(0, 9) < 2);
            bus.is_branch   = ($urandom_range(0, 9) < 3);
            bus.is_jump     = ($urandom_range(0, 9) < 1);
            bus.is_jump_reg = ($urandom_range(0, 19) < 1);
            bus.alu_zero    = $urandom_range(0, 1) == 1;
            bus.imm16       = 16'($urandom);
            bus.target26    = 26'($urandom);
            bus.reg_target  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            tick();
            n_cmp++;
            if ({bus.pc, bus.in_delay_slot, bus.active, bus.link_addr} !==
                {m_pc, m_slot, m_active, m_pc + 32'd8}) begin
                n_fail++;
                $display("FAIL random[%0d]: pc=%h ds=%b act=%b link=%h, expected pc=%h ds=%b act=%b link=%h",
                         i, bus.pc, bus.in_delay_slot, bus.active, bus.link_addr,
                         m_pc, m_slot, m_active, m_pc + 32'd8);
            end
            halted_cycles = m_active ? 0 : halted_cycles + 1;
            if (halted_cycles > 4) begin
                do_reset();
                halted_cycles = 0;
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        clear_inputs();
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall_in_delay();
        test_halt();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Program-counter and control-flow stage directly downstream of the ALU.
- Consumes the ALU `zero` flag: for every branch opcode, the ALU drives `zero=1` exactly when the branch is taken.
- Computes branch, jump and jump-register targets and implements the MIPS one-instruction branch delay slot.
- Owns the architectural PC and the CPU `active` flag; halts after a jump-register to address 0.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- HALT_ADDR, 32'h00000000, jump-register target that halts the CPU after its delay slot.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  freeze: no state changes while high.
- instr_valid  input  1  current instruction at `pc` completes this cycle.
- is_branch  input  1  conditional branch (BEQ/BNE/BGTZ/BLEZ/BGEZ/BLTZ family).
- is_jump  input  1  J/JAL (26-bit target).
- is_jump_reg  input  1  JR/JALR.
- alu_zero  input  1  ALU zero flag; 1 = branch taken.
- imm16  input  16  branch offset field.
- target26  input  26  jump index field.
- reg_target  input  32  rs value for JR/JALR.
- pc  output  32  address of current instruction.
- link_addr  output  32  `pc + 8`, combinational, for JAL/JALR/BxxAL writeback.
- in_delay_slot  output  1  current instruction is a delay slot.
- active  output  1  CPU running; 0 once halted.

Behaviour:
- Reset (async, immediate) values:
  - pc = RESET_VECTOR
  - state = SEQ
  - in_delay_slot = 0
  - active = 1
  - pending target register = 0
  - Reset asserted mid-delay-slot discards the pending redirect.
- Advance condition: `adv = instr_valid & ~stall & active`. With `adv=0` every register holds.
- Target arithmetic, all relative to the branch instruction's `pc`, modulo 2^32 (wrap silently):
  - branch: `pc + 4 + (sign_extend(imm16) << 2)`
  - jump: `{pc_plus4[31:28], target26, 2'b00}`
  - jump-register: `reg_target`, used as-is with no alignment masking.
- Redirect condition: `redir = is_jump | is_jump_reg | (is_branch & alu_zero)`.
- Priority when several decode flags are high: is_jump_reg > is_jump > is_branch.
- State machine:
  - SEQ, on adv:
    - If redir: latch the target, pc <= pc+4, go to DELAY.
    - If the redirect is jump-register with `reg_target == HALT_ADDR`: go to HALT_DELAY instead of DELAY.
    - Otherwise: pc <= pc+4.
  - DELAY (in_delay_slot=1), on adv: pc <= latched target, go to SEQ. Any branch/jump in the delay slot is ignored; the first target wins.
  - HALT_DELAY (in_delay_slot=1), on adv: pc <= HALT_ADDR, active <= 0, go to HALTED.
  - HALTED: pc and active hold until reset; all inputs ignored.
- Untaken branch (`is_branch & ~alu_zero`) behaves as a plain sequential instruction; its delay slot is not flagged.
- Stall during DELAY or HALT_DELAY holds both the state and the latched target.
- Latency: a redirect takes effect on the second advancing edge after the branch (one delay-slot instruction in between).
- link_addr: always `pc + 8` (wrapping), independent of state.

Test Plan:
- Reset, then 3 plain instructions with instr_valid=1 → pc: BFC00000, BFC00004, BFC00008, BFC0000C; active=1 throughout.
- Branch at pc=BFC00010, imm16=16'hFFFC, alu_zero=1 → next pc=BFC00014 with in_delay_slot=1, then pc=BFC00004; with alu_zero=0 instead → BFC00014, BFC00018.
- J at pc=BFC00020, target26=26'h0000100 → BFC00024 (delay slot), then B0000400.
- Stall held 3 cycles while in DELAY, with a second taken branch asserted in the delay slot → pc frozen during the stall, then the first target is taken and the second branch is ignored.
- JR with reg_target=0 at pc=BFC00030 → BFC00034 (delay), then pc=0 with active=0; further valid instructions leave pc=0.
- Async reset pulsed mid-DELAY (not on a clock edge) → pc=BFC00000 and in_delay_slot=0 immediately; the next advance gives BFC00004.
